// File: rtl/cache_pkg.sv
// Shared cache types: line/index sizes, the encoded queue entry and the
// output-queue state encoding.
package cache_pkg;

  localparam int CACHE_LINES = 16;
  localparam int CACHE_IDX_W = 4;

  typedef struct packed {
    logic [CACHE_IDX_W-1:0] index;
    logic                   hit;
    logic                   multi;
  } idx_entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_ONE,
    Q_FULL
  } q_state_t;

endpackage

// File: rtl/onehot_to_index.sv
// Combinational encoder: lowest set bit index of a per-line hit vector,
// plus any-set and two-or-more-set flags.
module onehot_to_index #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic [LINES-1:0] onehot_i,
  output logic [IDX_W-1:0] index_o,
  output logic             hit_o,
  output logic             multi_o
);

  // Scanning from the top down leaves the lowest set bit as the final winner.
  always_comb begin
    index_o = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (onehot_i[i]) begin
        index_o = IDX_W'(i);
      end
    end
  end

  assign hit_o   = |onehot_i;
  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign multi_o = |(onehot_i & (onehot_i - LINES'(1)));

endmodule

// File: rtl/cache_index_encoder.sv
// Encodes the tag-compare hit vector into a line index with hit/multi flags,
// buffers results in a 2-entry queue and counts multi-hit inputs.
module cache_index_encoder
  import cache_pkg::*;
#(
  parameter int LINES     = CACHE_LINES,
  parameter int IDX_W     = $clog2(LINES),
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LINES-1:0]     in_onehot_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IDX_W-1:0]     out_index_o,
  output logic                 out_hit_o,
  output logic                 out_multi_o,
  input  logic                 clr_err_i,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  q_state_t               state_q, state_d;
  idx_entry_t             head_q, head_d;
  idx_entry_t             tail_q, tail_d;
  idx_entry_t             enc;
  logic                   in_ready_q, in_ready_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic                   push, pop;

  onehot_to_index #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_encode (
    .onehot_i (in_onehot_i),
    .index_o  (enc.index),
    .hit_o    (enc.hit),
    .multi_o  (enc.multi)
  );

  assign push = in_valid_i & in_ready_q;
  assign pop  = out_valid_o & out_ready_i;

  // Head always holds the oldest entry; tail is only occupied in FULL.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      Q_EMPTY: begin
        if (push) begin
          head_d  = enc;
          state_d = Q_ONE;
        end
      end
      Q_ONE: begin
        if (push && pop) begin
          head_d = enc;
        end else if (push) begin
          tail_d  = enc;
          state_d = Q_FULL;
        end else if (pop) begin
          state_d = Q_EMPTY;
        end
      end
      Q_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = Q_ONE;
        end
      end
      default: state_d = Q_EMPTY;
    endcase
  end

  assign in_ready_d = (state_d != Q_FULL);

  // Clear wins over a simultaneous multi-hit push; the counter never wraps.
  always_comb begin
    err_d = err_q;
    if (clr_err_i) begin
      err_d = '0;
    end else if (push && enc.multi && (err_q != {ERR_CNT_W{1'b1}})) begin
      err_d = err_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Q_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != Q_EMPTY);
  assign out_index_o = head_q.index;
  assign out_hit_o   = head_q.hit;
  assign out_multi_o = head_q.multi;
  assign err_count_o = err_q;

endmodule
